// File: rtl/otter_crypto_pkg.sv
// otter_crypto_pkg: shared constants, FSM state type and Feistel helpers for the ENCRY unit.
package otter_crypto_pkg;

    localparam logic [6:0]  OPC_ENCRY = 7'b1011001;
    localparam logic [15:0] RC_BASE   = 16'h9E37;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} crypto_state_t;

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] t;
        t = {x, x} << n;
        return t[31:16];
    endfunction

    function automatic logic [15:0] feistel_f(input logic [15:0] x, input logic [15:0] k);
        return (rotl16(x, 4'd3) ^ k) + x;
    endfunction

    function automatic logic [15:0] round_key(input logic [31:0] k, input logic [1:0] i,
                                              input logic [15:0] base = RC_BASE);
        return k[15:0] ^ rotl16(k[31:16], {i, 2'b00}) ^ (base + {14'd0, i});
    endfunction

endpackage

// File: rtl/crypto_feistel_round.sv
// crypto_feistel_round: one combinational Feistel round, L' = R, R' = L ^ F(R, k).
module crypto_feistel_round
    import otter_crypto_pkg::*;
(
    input  logic [15:0] l_i,
    input  logic [15:0] r_i,
    input  logic [15:0] k_i,
    output logic [15:0] l_o,
    output logic [15:0] r_o
);

    assign l_o = r_i;
    assign r_o = l_i ^ feistel_f(r_i, k_i);

endmodule

// File: rtl/otter_crypto_unit.sv
// otter_crypto_unit: 4-round 16/16 Feistel cipher stepped in lockstep with the CU crypto_count.
module otter_crypto_unit #(
    parameter int          ROUNDS  = 4,
    parameter logic [15:0] RC_BASE = otter_crypto_pkg::RC_BASE
) (
    input  logic        CRY_CLK,
    input  logic        CRY_RESET_N,
    input  logic        CRY_FLUSH,
    input  logic        CRY_EN,
    input  logic [1:0]  CRY_COUNT,
    input  logic        CRY_DECRYPT,
    input  logic [31:0] CRY_DATA,
    input  logic [31:0] CRY_KEY,
    output logic [31:0] CRY_RESULT,
    output logic        CRY_DONE,
    output logic        CRY_BUSY,
    output logic        CRY_ERR
);

    import otter_crypto_pkg::*;

    if (ROUNDS != 4) begin : g_rounds_check
        $error("otter_crypto_unit: ROUNDS must be 4 to match the 2-bit CU count");
    end

    crypto_state_t state_q, state_d;
    logic [15:0]   l_q, l_d, r_q, r_d;
    logic [31:0]   hold_q, hold_d, key_q, key_d;
    logic          dir_q, dir_d, err_q, err_d;
    logic [1:0]    rnd_q, rnd_d;
    logic          start, in_run, lock_ok;
    logic [15:0]   rl_in, rr_in, rk_reg, rk_fin, rl_out, rr_out, fl_out, fr_out;

    assign start   = CRY_EN && CRY_COUNT == 2'd0;
    assign in_run  = state_q == RUN;
    assign lock_ok = CRY_EN && CRY_COUNT == rnd_q;

    // Round 0 works on the ports so operands are sampled only in the count-0 cycle.
    assign rl_in  = in_run ? l_q : CRY_DATA[31:16];
    assign rr_in  = in_run ? r_q : CRY_DATA[15:0];
    assign rk_reg = in_run ? round_key(key_q, dir_q ? ~rnd_q : rnd_q, RC_BASE)
                           : round_key(CRY_KEY, CRY_DECRYPT ? 2'd3 : 2'd0, RC_BASE);
    assign rk_fin = round_key(key_q, dir_q ? 2'd0 : 2'd3, RC_BASE);

    crypto_feistel_round u_reg_round (
        .l_i(rl_in), .r_i(rr_in), .k_i(rk_reg), .l_o(rl_out), .r_o(rr_out)
    );

    crypto_feistel_round u_fin_round (
        .l_i(l_q), .r_i(r_q), .k_i(rk_fin), .l_o(fl_out), .r_o(fr_out)
    );

    // Feistel is self-inverse under reversed keys, so both directions share the {R,L} output swap.
    assign CRY_DONE   = in_run && lock_ok && rnd_q == 2'd3 && !CRY_FLUSH;
    assign CRY_RESULT = CRY_DONE ? {fr_out, fl_out} : hold_q;
    assign CRY_BUSY   = in_run;
    assign CRY_ERR    = err_q;

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        hold_d  = hold_q;
        key_d   = key_q;
        dir_d   = dir_q;
        err_d   = err_q;
        rnd_d   = rnd_q;
        if (CRY_FLUSH) begin
            state_d = IDLE;
            rnd_d   = 2'd0;
            hold_d  = 32'd0;
            err_d   = 1'b0;
            l_d     = 16'd0;
            r_d     = 16'd0;
        end else if (in_run) begin
            if (!lock_ok) begin
                state_d = IDLE;
                rnd_d   = 2'd0;
                err_d   = 1'b1;
                l_d     = 16'd0;
                r_d     = 16'd0;
            end else if (rnd_q == 2'd3) begin
                state_d = HOLD;
                rnd_d   = 2'd0;
                hold_d  = {fr_out, fl_out};
            end else begin
                l_d   = rl_out;
                r_d   = rr_out;
                rnd_d = rnd_q + 2'd1;
            end
        end else if (start) begin
            state_d = RUN;
            rnd_d   = 2'd1;
            l_d     = rl_out;
            r_d     = rr_out;
            key_d   = CRY_KEY;
            dir_d   = CRY_DECRYPT;
            err_d   = 1'b0;
        end else if (CRY_EN) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge CRY_CLK or negedge CRY_RESET_N) begin
        if (!CRY_RESET_N) begin
            state_q <= IDLE;
            l_q     <= 16'd0;
            r_q     <= 16'd0;
            hold_q  <= 32'd0;
            key_q   <= 32'd0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            rnd_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: tb/tb_otter_crypto_unit.sv
// tb_otter_crypto_unit: scoreboard bench; stimulus queues expected results, a monitor checks each DONE.
module tb_otter_crypto_unit;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, en = 1'b0, dec = 1'b0;
    logic [1:0]  cnt = 2'd0;
    logic [31:0] data = 32'd0, key = 32'd0;
    logic [31:0] result;
    logic        done, busy, err;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    always #5 clk = ~clk;

    otter_crypto_unit dut (
        .CRY_CLK(clk), .CRY_RESET_N(rst_n), .CRY_FLUSH(flush), .CRY_EN(en),
        .CRY_COUNT(cnt), .CRY_DECRYPT(dec), .CRY_DATA(data), .CRY_KEY(key),
        .CRY_RESULT(result), .CRY_DONE(done), .CRY_BUSY(busy), .CRY_ERR(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        return n == 0 ? x : 16'((x << n) | (x >> (16 - n)));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] k, input bit dc);
        logic [15:0] l, r, t, sk;
        logic [15:0] rk[4];
        l = d[31:16];
        r = d[15:0];
        for (int i = 0; i < 4; i++) rk[i] = k[15:0] ^ rotl(k[31:16], 4 * i) ^ (16'h9E37 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            sk = dc ? rk[3 - i] : rk[i];
            t  = r;
            r  = l ^ 16'((rotl(r, 3) ^ sk) + r);
            l  = t;
        end
        return {r, l};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: result %h with nothing pending at %0t", result, $time);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    // Full count 0..3 sequence; scramble changes operands after count 0.
    task automatic op(input logic [31:0] d, input logic [31:0] k, input bit dc,
                      input logic [31:0] exp, input bit scramble);
        exp_q.push_back(exp);
        last_exp = exp;
        for (int c = 0; c < 4; c++) begin
            en  = 1'b1;
            cnt = 2'(c);
            if (c == 0 || !scramble) begin
                data = d;
                key  = k;
                dec  = dc;
            end else begin
                data = $urandom;
                key  = $urandom;
                dec  = ~dc;
            end
            @(negedge clk);
            check("busy", 32'(busy), 32'(c != 0));
            check("done", 32'(done), 32'(c == 3));
            if (c != 0) check("err", 32'(err), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input bit e, input logic [1:0] c);
        en  = e;
        cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ct, d, k;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(32'd0, 32'd0, 1'b0, 32'h0EAA9FAB, 1'b0);
        en = 1'b0;
        cnt = 2'd0;
        @(negedge clk);
        check("hold_zero_vec", result, 32'h0EAA9FAB);
        check("hold_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        ct = model(32'hDEADBEEF, 32'h01234567, 1'b0);
        op(32'hDEADBEEF, 32'h01234567, 1'b0, ct, 1'b0);
        op(ct, 32'h01234567, 1'b1, 32'hDEADBEEF, 1'b0);
        op(32'h12345678, 32'hCAFEF00D, 1'b0, model(32'h12345678, 32'hCAFEF00D, 1'b0), 1'b1);
        op(32'hA5A55A5A, 32'h0F0F0F0F, 1'b1, model(32'hA5A55A5A, 32'h0F0F0F0F, 1'b1), 1'b1);

        data = 32'h11112222;
        key  = 32'h33334444;
        dec  = 1'b0;
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        cnt = 2'd1;
        @(negedge clk);
        check("lock_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        en = 1'b0;
        cnt = 2'd0;
        @(negedge clk);
        check("lock_err", 32'(err), 32'd1);
        check("lock_busy", 32'(busy), 32'd0);
        check("lock_hold", result, last_exp);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lock_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        op(32'h11112222, 32'h33334444, 1'b0, model(32'h11112222, 32'h33334444, 1'b0), 1'b0);

        data = 32'h0BADF00D;
        key  = 32'h76543210;
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        flush = 1'b1;
        step(1'b1, 2'd2);
        flush = 1'b0;
        en = 1'b0;
        cnt = 2'd0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, 32'd0);
        check("flush_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        op(32'h01020304, 32'h05060708, 1'b0, model(32'h01020304, 32'h05060708, 1'b0), 1'b0);
        step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        cnt = 2'd2;
        #1 check("pre_reset_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("areset_result", result, 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        check("areset_err", 32'(err), 32'd0);
        en = 1'b0;
        cnt = 2'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            d  = $urandom;
            k  = $urandom;
            ct = model(d, k, 1'b0);
            op(d, k, 1'b0, ct, 1'b0);
            op(ct, k, 1'b1, d, 1'b0);
        end

        en = 1'b0;
        cnt = 2'd0;
        repeat (2) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
